// File: rtl/fir_pkg.sv
// Shared types for the FIR stream controller: FSM states, valid-pipe entry,
// and the flush counter width helper.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_WAIT_OUT,
    ST_CLEAR
  } state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } vp_entry_t;

  // Flush counter must reach TAPS+LAT-2; keep at least one bit.
  function automatic int flush_cnt_w(input int taps, input int lat);
    return (taps + lat > 1) ? $clog2(taps + lat) : 1;
  endfunction

endpackage

// File: rtl/fir_valid_pipe.sv
// LAT-deep shift register of {valid,last} tags that tracks samples through the
// filter pipeline; advances only when the filter is enabled.
module fir_valid_pipe
  import fir_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_en,
  input  vp_entry_t i_entry,
  output vp_entry_t o_tail
);

  vp_entry_t [LAT-1:0] r_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe <= '0;
    end else if (i_en) begin
      r_pipe[0] <= i_entry;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tail = r_pipe[LAT-1];

endmodule

// File: rtl/fir_stream_ctrl.sv
// Valid/ready sequencer around a free-running FIR core: gates the core enable,
// flushes TAPS-1 zeros after each frame and clears filter history between frames.
module fir_stream_ctrl
  import fir_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAPS  = 16,
  parameter int LAT   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] f_in,
  output logic             f_en,
  output logic             f_clr,
  input  logic [WIDTH-1:0] f_out,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int FC_W = flush_cnt_w(TAPS, LAT);
  localparam logic [FC_W-1:0] END_IDX  = FC_W'(TAPS + LAT - 2);
  localparam logic [FC_W-1:0] NVALID   = FC_W'(TAPS - 1);
  localparam logic [FC_W-1:0] LAST_IDX = FC_W'((TAPS > 1) ? TAPS - 2 : 0);

  state_e           r_state, w_state_nxt;
  logic [FC_W-1:0]  r_fcnt;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_valid, r_m_last, r_f_clr;
  logic             w_out_free, w_en;
  vp_entry_t        w_entry, w_tail;

  assign w_out_free = !r_m_valid || m_ready;
  assign w_en       = w_out_free && (((r_state == ST_RUN) && s_valid) || (r_state == ST_FLUSH));

  always_comb begin
    w_state_nxt = r_state;
    w_entry     = '0;
    f_in        = '0;
    case (r_state)
      ST_IDLE: if (s_valid) w_state_nxt = ST_RUN;
      ST_RUN: begin
        f_in          = s_data;
        w_entry.valid = 1'b1;
        w_entry.last  = (TAPS == 1) && s_last;
        if (w_en && s_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // First TAPS-1 flush advances produce the filter tail; the rest drain the pipe.
        w_entry.valid = (r_fcnt < NVALID);
        w_entry.last  = (TAPS > 1) && (r_fcnt == LAST_IDX);
        if (w_en && (r_fcnt == END_IDX)) w_state_nxt = ST_WAIT_OUT;
      end
      ST_WAIT_OUT: if (r_m_valid && r_m_last && m_ready) w_state_nxt = ST_CLEAR;
      ST_CLEAR:    w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  fir_valid_pipe #(.LAT(LAT)) u_vpipe (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_en),
    .i_entry (w_entry),
    .o_tail  (w_tail)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_fcnt      <= '0;
      r_frame_cnt <= '0;
      r_f_clr     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_f_clr <= (w_state_nxt == ST_CLEAR);
      if (r_state != ST_FLUSH) r_fcnt <= '0;
      else if (w_en)           r_fcnt <= r_fcnt + 1'b1;
      if ((r_state == ST_WAIT_OUT) && (w_state_nxt == ST_CLEAR))
        r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Output register: loads on every advance, otherwise drains once accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_en) begin
      r_m_data  <= f_out;
      r_m_valid <= w_tail.valid;
      r_m_last  <= w_tail.valid && w_tail.last;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  assign s_ready   = (r_state == ST_RUN) && w_out_free;
  assign f_en      = w_en;
  assign f_clr     = r_f_clr;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign busy      = (r_state != ST_IDLE);
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl (TAPS=4, LAT=2) with a small FIR core model
// using coefficients h = {1,2,3,4}.
module tb_fir_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [15:0] f_in, f_out, m_data;
  logic        f_en, f_clr, m_valid, m_last, m_ready, busy;
  logic [15:0] frame_cnt;

  int n_chk = 0;
  int n_err = 0;
  int clr_cnt = 0;
  logic [15:0] got_d[$];
  logic        got_l[$];

  always #5 clk = ~clk;

  fir_stream_ctrl #(.WIDTH(16), .TAPS(4), .LAT(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .f_in(f_in), .f_en(f_en), .f_clr(f_clr), .f_out(f_out),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  // FIR core model: 4-tap delay line plus 2-stage result pipeline.
  logic [15:0] d0, d1, d2, p0, p1;
  function automatic logic [15:0] fir_y(input logic [15:0] x, a, b, c);
    return x + (a << 1) + (b + (b << 1)) + (c << 2);
  endfunction
  always @(posedge clk) begin
    if (f_clr) begin
      d0 <= '0; d1 <= '0; d2 <= '0; p0 <= '0; p1 <= '0;
    end else if (f_en) begin
      d0 <= f_in; d1 <= d0; d2 <= d1;
      p0 <= fir_y(f_in, d0, d1, d2);
      p1 <= p0;
    end
  end
  assign f_out = p1;

  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
    end
    if (reset && f_clr) clr_cnt++;
  end

  task automatic send(input logic [15:0] d, input logic last, input int gap);
    bit ok = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL send_handshake data=%0d never accepted", d); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL wait_idle busy stuck=%0b expected 0", busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = 0; s_last = 0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({m_valid, m_last, busy, f_clr} !== 4'b0001 || m_data !== 16'd0 || frame_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state got v=%0b l=%0b busy=%0b clr=%0b d=%0d cnt=%0d expected 0,0,0,1,0,0",
               m_valid, m_last, busy, f_clr, m_data, frame_cnt);
    end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (f_clr !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release got clr=%0b busy=%0b expected 0,0", f_clr, busy);
    end
  endtask

  task automatic test_frame();
    logic [15:0] exp_d[] = '{1, 4, 10, 16, 17, 12};
    got_d.delete(); got_l.delete(); clr_cnt = 0;
    send(1, 0, 0); send(2, 0, 0); send(3, 1, 0);
    wait_idle();
    n_chk++;
    if (got_d.size() != 6) begin n_err++; $display("FAIL frame_count got %0d expected 6", got_d.size()); end
    for (int i = 0; i < 6 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 5)) begin
        n_err++; $display("FAIL frame_out[%0d] got %0d/%0b expected %0d/%0b", i, got_d[i], got_l[i], exp_d[i], i == 5);
      end
    end
    n_chk++;
    if (frame_cnt !== 16'd1 || clr_cnt != 1) begin
      n_err++; $display("FAIL frame_done got cnt=%0d clr=%0d expected 1,1", frame_cnt, clr_cnt);
    end
  endtask

  task automatic test_single();
    logic [15:0] exp_d[] = '{5, 10, 15, 20};
    got_d.delete(); got_l.delete(); clr_cnt = 0;
    send(5, 1, 0);
    wait_idle();
    n_chk++;
    if (got_d.size() != 4) begin n_err++; $display("FAIL single_count got %0d expected 4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
        n_err++; $display("FAIL single_out[%0d] got %0d/%0b expected %0d/%0b", i, got_d[i], got_l[i], exp_d[i], i == 3);
      end
    end
    n_chk++;
    if (frame_cnt !== 16'd2 || clr_cnt != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_done got cnt=%0d clr=%0d busy=%0b expected 2,1,0", frame_cnt, clr_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_d[] = '{2, 5, 11, 18, 15, 15, 4};
    got_d.delete(); got_l.delete();
    fork
      begin send(2, 0, 0); send(1, 0, 0); send(3, 0, 0); send(1, 1, 0); end
      begin
        logic [15:0] held;
        bit seen = 0;
        for (int c = 0; c < 100; c++) begin
          @(posedge clk); #1;
          if (m_valid) begin seen = 1; break; end
        end
        m_ready = 1'b0; held = m_data;
        repeat (5) begin
          @(negedge clk);
          n_chk++;
          if (!seen || f_en !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== held) begin
            n_err++;
            $display("FAIL stall got en=%0b rdy=%0b v=%0b d=%0d expected 0,0,1,%0d", f_en, s_ready, m_valid, m_data, held);
          end
        end
        @(posedge clk); #1; m_ready = 1'b1;
      end
    join
    wait_idle();
    n_chk++;
    if (got_d.size() != 7) begin n_err++; $display("FAIL bp_count got %0d expected 7", got_d.size()); end
    for (int i = 0; i < 7 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 6)) begin
        n_err++; $display("FAIL bp_out[%0d] got %0d/%0b expected %0d/%0b", i, got_d[i], got_l[i], exp_d[i], i == 6);
      end
    end
  endtask

  task automatic test_gaps();
    logic [15:0] exp_d[] = '{2, 5, 11, 18, 15, 15, 4};
    got_d.delete(); got_l.delete();
    send(2, 0, 2); send(1, 0, 2); send(3, 0, 2); send(1, 1, 2);
    wait_idle();
    n_chk++;
    if (got_d.size() != 7) begin n_err++; $display("FAIL gap_count got %0d expected 7", got_d.size()); end
    for (int i = 0; i < 7 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 6)) begin
        n_err++; $display("FAIL gap_out[%0d] got %0d/%0b expected %0d/%0b", i, got_d[i], got_l[i], exp_d[i], i == 6);
      end
    end
  endtask

  task automatic test_reset_flush();
    logic [15:0] exp_d[] = '{1, 4, 10, 16, 17, 12};
    int nlast = 0;
    got_d.delete(); got_l.delete();
    send(1, 0, 0); send(2, 0, 0); send(3, 1, 0);
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL flush_reset got v=%0b l=%0b busy=%0b cnt=%0d expected 0,0,0,0", m_valid, m_last, busy, frame_cnt);
    end
    @(posedge clk); #1; reset = 1'b1;
    foreach (got_l[i]) if (got_l[i]) nlast++;
    n_chk++;
    if (nlast != 0) begin n_err++; $display("FAIL flush_partial_last got %0d expected 0", nlast); end
    got_d.delete(); got_l.delete();
    send(1, 0, 0); send(2, 0, 0); send(3, 1, 0);
    wait_idle();
    n_chk++;
    if (got_d.size() != 6) begin n_err++; $display("FAIL rerun_count got %0d expected 6", got_d.size()); end
    for (int i = 0; i < 6 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 5)) begin
        n_err++; $display("FAIL rerun_out[%0d] got %0d/%0b expected %0d/%0b", i, got_d[i], got_l[i], exp_d[i], i == 5);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d[] = '{5, 10, 15, 20, 2, 5, 11, 18, 15, 15, 4};
    logic [15:0] cnt0 = frame_cnt;
    got_d.delete(); got_l.delete(); clr_cnt = 0;
    send(5, 1, 0);
    send(2, 0, 0); send(1, 0, 0); send(3, 0, 0); send(1, 1, 0);
    wait_idle();
    n_chk++;
    if (got_d.size() != 11) begin n_err++; $display("FAIL b2b_count got %0d expected 11", got_d.size()); end
    for (int i = 0; i < 11 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3 || i == 10)) begin
        n_err++; $display("FAIL b2b_out[%0d] got %0d/%0b expected %0d/%0b", i, got_d[i], got_l[i], exp_d[i], (i == 3 || i == 10));
      end
    end
    n_chk++;
    if (frame_cnt !== 16'(cnt0 + 16'd2) || clr_cnt != 2) begin
      n_err++; $display("FAIL b2b_done got cnt=%0d clr=%0d expected %0d,2", frame_cnt, clr_cnt, cnt0 + 16'd2);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_single();
    test_backpressure();
    test_gaps();
    test_reset_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
